// File: rtl/win_ctrl_pkg.sv
// Shared types and constants for the win-image overlay sequencer and its blend stage.
package win_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_IN  = 2'd1,
        ST_SHOW     = 2'd2,
        ST_FADE_OUT = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam int WIN_SIZE   = 256;
    localparam int LVL_MAX    = 16;
    localparam int PIPE_DEPTH = 3;

endpackage

// File: rtl/rgb444_blend.sv
// Registered per-channel blend of two RGB444 pixels: chan = (fg*L + bg*(16-L)) >> 4.
module rgb444_blend
    import win_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_vld,
    input  rgb444_t    fg_rgb,
    input  rgb444_t    bg_rgb,
    input  logic [4:0] level,
    output rgb444_t    out_rgb
);

    rgb444_t out_q, out_d;

    // Weights sum to 16, so the 9-bit sum never exceeds 240 and the result fits in 4 bits.
    function automatic logic [3:0] mix_chan(input logic [3:0] fg, input logic [3:0] bg,
                                            input logic [4:0] lvl);
        logic [8:0] acc;
        acc = 9'(fg) * 9'(lvl) + 9'(bg) * (9'(LVL_MAX) - 9'(lvl));
        return 4'(acc >> 4);
    endfunction

    always_comb begin
        out_d = '0;
        if (in_vld) begin
            out_d.r = mix_chan(fg_rgb.r, bg_rgb.r, level);
            out_d.g = mix_chan(fg_rgb.g, bg_rgb.g, level);
            out_d.b = mix_chan(fg_rgb.b, bg_rgb.b, level);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_rgb = out_q;

endmodule

// File: rtl/win_overlay_ctrl.sv
// Win-image overlay sequencer: centred 256x256 window mapping, ROM addressing and 3-cycle compositing pipe.
// Define WIN_OVERLAY_FADE_EN to build the fade-in/fade-out blend; otherwise the overlay switches on frame_start.
module win_overlay_ctrl
    import win_ctrl_pkg::*;
#(
    parameter int unsigned X0       = 192,
    parameter int unsigned Y0       = 112,
    parameter int unsigned FADE_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        win_pulse,
    input  logic        restart,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [11:0] bg_rgb,
    output logic [15:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb_out,
    output logic        rgb_valid,
    output logic        active,
    output logic        done
);

    localparam logic [9:0] WIN_SZ   = 10'(WIN_SIZE);
    localparam logic [4:0] LVL_FULL = 5'(LVL_MAX);

    state_e      state_q, state_d;
    logic [4:0]  level_q, level_d;
    logic        done_q, done_d;

    logic [9:0]  dx, dy;
    logic        in_win;

    logic        vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    rgb444_t     bg_p1_q, bg_p1_d, bg_p2_q, bg_p2_d;
    logic [4:0]  lvl_p1_q, lvl_p1_d, lvl_p2_q, lvl_p2_d;
    logic        rgb_valid_q, rgb_valid_d;

    // Unsigned wrap makes pixels left of / above the window land at dx/dy >= 256.
    assign dx     = pix_x - 10'(X0);
    assign dy     = pix_y - 10'(Y0);
    assign in_win = (dx < WIN_SZ) && (dy < WIN_SZ);

`ifdef WIN_OVERLAY_FADE_EN
    logic [7:0] frm_cnt_q, frm_cnt_d;
    logic       step;

    assign step = frame_start && (frm_cnt_q == 8'(FADE_DIV - 1));

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_pulse) state_d = ST_FADE_IN;
            end
            ST_FADE_IN: begin
                if (restart) begin
                    state_d = ST_FADE_OUT;
                end else if (step) begin
                    level_d = level_q + 5'd1;
                    if (level_d == LVL_FULL) state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (restart) state_d = ST_FADE_OUT;
            end
            ST_FADE_OUT: begin
                if (win_pulse && !restart) begin
                    state_d = ST_FADE_IN;
                end else if (step) begin
                    if (level_q <= 5'd1) begin
                        level_d = 5'd0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        level_d = level_q - 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = 5'd0;
            end
        endcase

        // Restart the divider on every state change so each step spans FADE_DIV whole frames.
        frm_cnt_d = frm_cnt_q;
        if (state_d != state_q) begin
            frm_cnt_d = 8'd0;
        end else if (frame_start) begin
            frm_cnt_d = step ? 8'd0 : frm_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_cnt_q <= 8'd0;
        end else begin
            frm_cnt_q <= frm_cnt_d;
        end
    end
`else
    logic       leave_q, leave_d;
    logic [7:0] div_unused;

    assign div_unused = 8'(FADE_DIV);

    // A restart in SHOW is held until the next frame boundary so the image never tears mid-frame.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        leave_d = leave_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_pulse) state_d = ST_SHOW;
            end
            ST_SHOW: begin
                if (frame_start) begin
                    if (leave_q || restart) begin
                        state_d = ST_IDLE;
                        level_d = 5'd0;
                        leave_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        level_d = LVL_FULL;
                    end
                end else if (restart) begin
                    leave_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = 5'd0;
                leave_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leave_q <= 1'b0;
        end else begin
            leave_q <= leave_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            level_q <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            done_q  <= done_d;
        end
    end

    // Level is captured with the pixel and carried down the pipe; outside the window it is forced to 0.
    always_comb begin
        vld_p1_d    = pix_valid;
        rom_addr_d  = in_win ? {dy[7:0], dx[7:0]} : 16'h0000;
        bg_p1_d     = rgb444_t'(bg_rgb);
        lvl_p1_d    = in_win ? level_q : 5'd0;
        vld_p2_d    = vld_p1_q;
        bg_p2_d     = bg_p1_q;
        lvl_p2_d    = lvl_p1_q;
        rgb_valid_d = vld_p2_q;
    end

    // Stage boundaries: p1 = ROM address issued, p2 = ROM data returns, then the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            rom_addr_q  <= 16'h0000;
            vld_p2_q    <= 1'b0;
            rgb_valid_q <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            rom_addr_q  <= rom_addr_d;
            vld_p2_q    <= vld_p2_d;
            rgb_valid_q <= rgb_valid_d;
        end
        bg_p1_q  <= bg_p1_d;
        lvl_p1_q <= lvl_p1_d;
        bg_p2_q  <= bg_p2_d;
        lvl_p2_q <= lvl_p2_d;
    end

`ifdef WIN_OVERLAY_FADE_EN
    rgb444_t blend_rgb;

    rgb444_blend u_blend (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (vld_p2_q),
        .fg_rgb  (rgb444_t'(rom_data)),
        .bg_rgb  (bg_p2_q),
        .level   (lvl_p2_q),
        .out_rgb (blend_rgb)
    );

    assign rgb_out = blend_rgb;
`else
    rgb444_t rgb_out_q, rgb_out_d;

    always_comb begin
        rgb_out_d = '0;
        if (vld_p2_q) begin
            rgb_out_d = (lvl_p2_q == LVL_FULL) ? rgb444_t'(rom_data) : bg_p2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out_q <= '0;
        end else begin
            rgb_out_q <= rgb_out_d;
        end
    end

    assign rgb_out = rgb_out_q;
`endif

    assign rom_addr  = rom_addr_q;
    assign rgb_valid = rgb_valid_q;
    assign active    = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule
